// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line, sitting between IF and memctrl.
// Hits return in one cycle; misses issue a single-word refill and forward the returned word.
module icache #(
  parameter int INDEX_WIDTH = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_pc_get,
  input  logic [31:0] if_pc_address,
  output logic        if_done,
  output logic [31:0] if_inst,
  output logic        mem_get,
  output logic [31:0] mem_address,
  input  logic        mem_done,
  input  logic [31:0] mem_inst
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 16 - INDEX_WIDTH;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic                     if_done_q, if_done_d;
  logic [31:0]              if_inst_q, if_inst_d;
  logic                     mem_get_q, mem_get_d;
  logic [31:0]              mem_address_q, mem_address_d;

  logic [TAG_W-1:0]         tag_mem [LINES];
  logic [31:0]              data_mem [LINES];

  logic [INDEX_WIDTH-1:0]   req_index, fill_index;
  logic [TAG_W-1:0]         req_tag, fill_tag;
  logic                     req_io, fill_io, hit, fill_we;

  // The outstanding refill address doubles as the latched index/tag for the fill.
  assign req_index  = if_pc_address[INDEX_WIDTH+1:2];
  assign req_tag    = if_pc_address[17:INDEX_WIDTH+2];
  assign req_io     = (if_pc_address[17:16] == 2'b11);
  assign fill_index = mem_address_q[INDEX_WIDTH+1:2];
  assign fill_tag   = mem_address_q[17:INDEX_WIDTH+2];
  assign fill_io    = (mem_address_q[17:16] == 2'b11);
  assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag) && !req_io;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    if_done_d     = if_done_q;
    if_inst_d     = if_inst_q;
    mem_get_d     = mem_get_q;
    mem_address_d = mem_address_q;
    fill_we       = 1'b0;
    if (rdy_in) begin
      if_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // A request still held during the if_done cycle was already served.
          if (if_pc_get && !if_done_q) begin
            if (hit) begin
              if_done_d = 1'b1;
              if_inst_d = data_mem[req_index];
            end else begin
              mem_get_d     = 1'b1;
              mem_address_d = {if_pc_address[31:2], 2'b00};
              state_d       = MISS;
            end
          end
        end
        MISS: begin
          if (mem_done) begin
            mem_get_d = 1'b0;
            state_d   = IDLE;
            if (!fill_io) begin
              fill_we             = 1'b1;
              valid_d[fill_index] = 1'b1;
            end
            if (if_pc_get) begin
              if_done_d = 1'b1;
              if_inst_d = mem_inst;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      if_done_q     <= 1'b0;
      if_inst_q     <= '0;
      mem_get_q     <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      if_done_q     <= if_done_d;
      if_inst_q     <= if_inst_d;
      mem_get_q     <= mem_get_d;
      mem_address_q <= mem_address_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we && !rst_in) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_inst;
    end
  end

  assign if_done     = if_done_q;
  assign if_inst     = if_inst_q;
  assign mem_get     = mem_get_q;
  assign mem_address = mem_address_q;

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: a line-level cache model predicts each response,
// a negedge monitor pops and compares whenever the cache presents if_done or a new refill.
module tb_icache;

  localparam int IW    = 7;
  localparam int LINES = 1 << IW;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_pc_get = 1'b0;
  logic [31:0] if_pc_address = '0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        if_done, mem_get;
  logic [31:0] if_inst, mem_address;

  icache #(.INDEX_WIDTH(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_pc_get(if_pc_get), .if_pc_address(if_pc_address),
    .if_done(if_done), .if_inst(if_inst),
    .mem_get(mem_get), .mem_address(mem_address),
    .mem_done(mem_done), .mem_inst(mem_inst)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_mem_q[$];

  // Reference model: what each line holds, keyed by the full word address bits [17:2].
  bit          m_valid [LINES];
  logic [15:0] m_key   [LINES];
  logic [31:0] m_data  [LINES];

  logic        prev_done = 1'b0;
  logic        prev_mg = 1'b0;
  logic [31:0] prev_ma = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = idx_of(a);
    return !is_io(a) && m_valid[i] && (m_key[i] == a[17:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_done <= 1'b0;
      prev_mg   <= 1'b0;
    end else begin
      if (if_done) begin
        chk("if_done_one_cycle", {31'b0, prev_done}, 32'd0);
        chk("if_done_pending_fetch", {31'b0, exp_inst_q.size() > 0}, 32'd1);
        if (exp_inst_q.size() > 0) chk("if_inst", if_inst, exp_inst_q.pop_front());
      end
      if (mem_get && !prev_mg) begin
        chk("mem_get_pending_refill", {31'b0, exp_mem_q.size() > 0}, 32'd1);
        if (exp_mem_q.size() > 0) chk("mem_address", mem_address, exp_mem_q.pop_front());
      end else if (mem_get) begin
        chk("mem_address_held", mem_address, prev_ma);
      end
      prev_done <= if_done;
      prev_mg   <= mem_get;
      prev_ma   <= mem_address;
    end
  end

  // One IF fetch; memctrl answers after lat cycles of mem_get. IF keeps the request
  // high for one extra cycle after if_done to exercise the no-double-serve rule.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] fill, input int lat,
                       input bit abandon_in, input bit freeze);
    bit hit, abandon, done, filled, froze;
    int i, cyc, mem_cnt, want;
    hit = model_hit(addr);
    i = idx_of(addr);
    abandon = abandon_in && !hit;
    done = 0; filled = 0; froze = 0; cyc = 0; mem_cnt = 0;
    want = hit ? 1 : lat + 2 + (freeze ? 3 : 0);
    if (hit) begin
      exp_inst_q.push_back(m_data[i]);
    end else begin
      exp_mem_q.push_back({addr[31:2], 2'b00});
      if (!abandon) exp_inst_q.push_back(fill);
      if (!is_io(addr)) begin
        m_valid[i] = 1'b1;
        m_key[i]   = addr[17:2];
        m_data[i]  = fill;
      end
    end
    if_pc_address = addr;
    if_pc_get = 1'b1;
    while (!done && cyc < 300) begin
      @(posedge clk_in); #1; cyc++;
      if (mem_done) begin
        mem_done = 1'b0;
        filled = 1;
      end
      if (if_done) begin
        done = 1;
        if (!hit) chk("mem_get_after_fill", {31'b0, mem_get}, 32'd0);
      end else if (abandon && filled && !mem_get) begin
        done = 1;
      end else if (mem_get && !filled) begin
        if (freeze && mem_cnt == 1 && !froze) begin
          froze = 1;
          rdy_in = 1'b0;
          repeat (3) begin
            @(posedge clk_in); #1; cyc++;
            chk("freeze_mem_get", {31'b0, mem_get}, 32'd1);
            chk("freeze_if_done", {31'b0, if_done}, 32'd0);
          end
          rdy_in = 1'b1;
        end
        if (mem_cnt == lat) begin
          mem_done = 1'b1;
          mem_inst = fill;
          if (abandon) if_pc_get = 1'b0;
        end
        mem_cnt++;
      end
    end
    chk("fetch_completed", {31'b0, done}, 32'd1);
    if (done && !abandon) chk(hit ? "hit_latency" : "miss_latency", cyc, want);
    @(posedge clk_in); #1;
    if_pc_get = 1'b0;
    mem_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, addr;
    logic [8:0]  tag9;
    int lat, tsel;
    bit ab, fz;
    model_reset();
    #1 rst_in = 1'b1;
    #2;
    chk("reset_if_done", {31'b0, if_done}, 32'd0);
    chk("reset_if_inst", if_inst, 32'd0);
    chk("reset_mem_get", {31'b0, mem_get}, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    fetch(32'h0000_0000, 32'h0000_0513, 5, 0, 0);   // cold miss
    fetch(32'h0000_0000, 32'hDEAD_BEEF, 5, 0, 0);   // hit
    fetch(32'h0000_0200, 32'h1111_2222, 3, 0, 0);   // conflict replaces line 0
    fetch(32'h0000_0000, 32'h0000_0513, 2, 0, 0);   // misses again
    fetch(32'h0000_0010, 32'h0010_0093, 4, 1, 0);   // abandoned refill
    fetch(32'h0000_0010, 32'hBAD0_BAD0, 4, 0, 0);   // hit on the abandoned fill
    fetch(32'h0000_0024, 32'h0240_0024, 4, 0, 1);   // freeze mid-miss

    // Reset pulse mid-miss aborts the refill.
    exp_mem_q.push_back(32'h0000_0028);
    if_pc_address = 32'h0000_0028;
    if_pc_get = 1'b1;
    @(posedge clk_in); #1;
    chk("abort_mem_get_raised", {31'b0, mem_get}, 32'd1);
    @(negedge clk_in); #2;
    rst_in = 1'b1;
    #1;
    chk("abort_mem_get", {31'b0, mem_get}, 32'd0);
    chk("abort_mem_address", mem_address, 32'd0);
    chk("abort_if_done", {31'b0, if_done}, 32'd0);
    if_pc_get = 1'b0;
    model_reset();
    exp_inst_q.delete();
    exp_mem_q.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    fetch(32'h0000_0028, 32'h0280_0028, 2, 0, 0);
    fetch(32'h0000_0000, 32'h0000_0513, 1, 0, 0);

    fetch(32'h0003_0000, 32'hA0A0_0001, 2, 0, 0);   // I/O space never cached
    fetch(32'h0003_0000, 32'hA0A0_0002, 3, 0, 0);

    for (int n = 0; n < 100; n++) begin
      r = $urandom();
      tsel = $urandom_range(0, 4);
      tag9 = (tsel == 4) ? 9'h180 : 9'(tsel);
      addr = {r[13:0], tag9, 7'($urandom_range(0, 3)), 2'b00};
      lat = $urandom_range(0, 6);
      ab = ($urandom_range(0, 4) == 0);
      fz = (lat >= 1) && ($urandom_range(0, 5) == 0);
      fetch(addr, $urandom(), lat, ab, fz);
    end

    repeat (3) @(posedge clk_in);
    #1;
    chk("scoreboard_inst_drained", exp_inst_q.size(), 32'd0);
    chk("scoreboard_mem_drained", exp_mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7, giving a 2^INDEX_WIDTH-line direct-mapped cache with one 32-bit word per line.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rdy_in  input  1  when low, freezes all state and holds all outputs.
REQ-005 SHALL have port if_pc_get  input  1  fetch request from IF, held high until if_done.
REQ-006 SHALL have port if_pc_address  input  32  fetch byte address (word-aligned; bits [17:2] used).
REQ-007 SHALL have port if_done  output  1  one-cycle pulse: if_inst valid.
REQ-008 SHALL have port if_inst  output  32  fetched instruction.
REQ-009 SHALL have port mem_get  output  1  refill request to memctrl, held until mem_done.
REQ-010 SHALL have port mem_address  output  32  refill word address.
REQ-011 SHALL have port mem_done  input  1  one-cycle pulse: mem_inst valid.
REQ-012 SHALL have port mem_inst  input  32  refill data from memctrl.

Function
REQ-013 SHALL decompose the address as index = addr[INDEX_WIDTH+1:2], tag = addr[17:INDEX_WIDTH+2]; bits [31:18] and [1:0] ignored.
REQ-014 SHALL keep per line: valid bit, tag, 32-bit data; only the valid bits are reset.
REQ-015 SHALL implement the states IDLE and MISS; all outputs registered.
REQ-016 IDLE, if_pc_get=1, if_done=0 this cycle, valid and tag match (hit): next cycle if_done=1, if_inst=line data; state stays IDLE.
REQ-017 IDLE, if_pc_get=1, if_done=0, no hit (miss): latch address; next cycle mem_get=1, mem_address={addr[31:2],2'b00}; state becomes MISS.
REQ-018 IDLE SHALL ignore if_pc_get in any cycle where if_done is high, so a held request is not served twice.
REQ-019 MISS: mem_get and mem_address held constant until mem_done=1.
REQ-020 MISS with mem_done=1: write mem_inst, latched tag, valid=1 into the latched index; next cycle mem_get=0, state IDLE.
REQ-021 Same MISS edge: if if_pc_get=1, next cycle if_done=1 and if_inst=mem_inst; if if_pc_get=0 (request abandoned by branch redirect), if_done stays 0 but the fill still occurs.
REQ-022 Hit latency SHALL be 1 cycle from request sample to if_done; miss latency SHALL be memctrl latency plus 1 cycle after mem_done.
REQ-023 Addresses with addr[17:16]=2'b11 (I/O space) SHALL always miss and never write a line.
REQ-024 if_done SHALL never be high for two consecutive cycles.
REQ-025 With rdy_in=0, no state, array or output SHALL change; mem_done arriving while rdy_in=0 is not required to be captured (memctrl is frozen too).

Reset
REQ-026 While rst_in=1, regardless of clock: state=IDLE, all valid bits=0, if_done=0, if_inst=0, mem_get=0, mem_address=0.
REQ-027 Reset asserted during MISS SHALL abort the refill with no line written; the first fetch after release SHALL miss.

Verification
REQ-028 Cold miss: reset, fetch 0x00000000, mem_done 5 cycles later with 0x00000513 -> mem_get=1 addr 0x0 until mem_done; if_done=1, if_inst=0x00000513 next cycle; mem_get=0.
REQ-029 Hit: refetch 0x00000000 -> if_done=1, if_inst=0x00000513 one cycle later; mem_get stays 0.
REQ-030 Conflict: fill 0x00000000, fetch 0x00000200 (same index, tag 1) -> miss, refill, line replaced; refetch 0x00000000 -> miss again.
REQ-031 Abort: fetch 0x00000010 miss, drop if_pc_get before mem_done (data 0x00100093) -> no if_done; refetch 0x00000010 -> hit, if_inst=0x00100093.
REQ-032 Freeze and reset: rdy_in=0 for 3 cycles mid-MISS -> outputs unchanged; rst_in pulse mid-MISS -> mem_get=0 immediately, next fetch misses.
REQ-033 I/O: fetch 0x00030000 twice -> two refills, no hit.
